// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared pipeline types and constants (IF/ID payload layout, NOP).
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_buf
// Brief    : Single skid entry plus source mux feeding the main stage register.
// Revision : 1.0
// ============================================================================
module pipe_skid_buf #(
    parameter int               WIDTH  = 96,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] in_data,
    output logic             skid_valid,
    output logic [WIDTH-1:0] skid_data,
    output logic [WIDTH-1:0] next_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // load and drain are exclusive: load needs a blocked main entry, drain a free one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (drain) begin
            r_valid <= 1'b0;
        end
    end

    assign skid_valid = r_valid;
    assign skid_data  = r_data;
    assign next_data  = r_valid ? r_data : in_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_elastic
// Brief    : Elastic valid/ready pipeline register with flush, optional skid
//            entry and saturating stall-cycle counter.
// Revision : 1.0
// ============================================================================
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = IF_ID_W,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               SKID   = 1,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_adv;
    logic             w_acc;
    logic             w_main_free;
    logic             w_fill;
    logic             w_in_ready;
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_next_data;

    // flush overrides a stall, so a downstream handshake in that cycle still consumes
    assign w_adv       = r_out_valid & out_ready & (~stall | flush);
    assign w_acc       = in_valid & w_in_ready;
    assign w_main_free = ~r_out_valid | w_adv;
    assign w_fill      = w_skid_valid | w_acc;

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] w_skid_data;

            pipe_skid_buf #(
                .WIDTH  (WIDTH),
                .BUBBLE (BUBBLE)
            ) u_skid (
                .clk        (clk),
                .rst_n      (rst_n),
                .flush      (flush),
                .load       (w_acc & ~w_main_free),
                .drain      (w_skid_valid & w_main_free),
                .in_data    (in_data),
                .skid_valid (w_skid_valid),
                .skid_data  (w_skid_data),
                .next_data  (w_next_data)
            );

            assign w_in_ready = ~w_skid_valid;
        end else begin : g_no_skid
            assign w_skid_valid = 1'b0;
            assign w_next_data  = in_data;
            assign w_in_ready   = w_main_free;
        end
    endgenerate

    // out_data is rewritten to BUBBLE in the same update that clears out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= BUBBLE;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_out_data  <= BUBBLE;
        end else if (w_main_free) begin
            if (w_fill) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_next_data;
            end else begin
                r_out_valid <= 1'b0;
                r_out_data  <= BUBBLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !w_adv && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign occupancy = {1'b0, r_out_valid} + {1'b0, w_skid_valid};
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_elastic
// Brief    : Scoreboard bench for pipe_stage_elastic, SKID=1 and SKID=0 builds.
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_elastic;

    localparam int          W       = 32;
    localparam logic [W-1:0] c_bub  = 32'h0000_0013;
    localparam int          A_MAX   = 15;
    localparam int          B_MAX   = 255;

    logic clk = 1'b0;
    logic rst_n;

    logic         a_in_valid, a_in_ready, a_stall, a_flush, a_out_valid, a_out_ready;
    logic [W-1:0] a_in_data, a_out_data;
    logic [1:0]   a_occupancy;
    logic [3:0]   a_stall_cnt;

    logic         b_in_valid, b_in_ready, b_stall, b_flush, b_out_valid, b_out_ready;
    logic [W-1:0] b_in_data, b_out_data;
    logic [1:0]   b_occupancy;
    logic [7:0]   b_stall_cnt;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int cnta, cntb;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(W), .BUBBLE(c_bub), .SKID(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .stall(a_stall), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occupancy), .stall_cnt(a_stall_cnt)
    );

    pipe_stage_elastic #(.WIDTH(W), .BUBBLE(c_bub), .SKID(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .stall(b_stall), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mon_a();
        bit mv, madv, rdy;
        mv   = (qa.size() != 0);
        madv = mv & a_out_ready & (~a_stall | a_flush);
        rdy  = (qa.size() < 2);
        chk("a_valid", 32'(a_out_valid), 32'(mv));
        if (mv) chk("a_data", a_out_data, qa[0]);
        else    chk("a_bubble", a_out_data, c_bub);
        chk("a_occ", 32'(a_occupancy), 32'(qa.size()));
        chk("a_in_ready", 32'(a_in_ready), 32'(rdy));
        chk("a_stall_cnt", 32'(a_stall_cnt), 32'(cnta));
        if (rst_n) begin
            if (mv && !madv && cnta < A_MAX) cnta++;
            if (madv) void'(qa.pop_front());
            if (a_flush) qa.delete();
            else if (a_in_valid && rdy) qa.push_back(a_in_data);
        end
    endtask

    task automatic mon_b();
        bit mv, madv, rdy;
        mv   = (qb.size() != 0);
        madv = mv & b_out_ready & (~b_stall | b_flush);
        rdy  = ~mv | madv;
        chk("b_valid", 32'(b_out_valid), 32'(mv));
        if (mv) chk("b_data", b_out_data, qb[0]);
        else    chk("b_bubble", b_out_data, c_bub);
        chk("b_occ", 32'(b_occupancy), 32'(qb.size()));
        chk("b_in_ready", 32'(b_in_ready), 32'(rdy));
        chk("b_stall_cnt", 32'(b_stall_cnt), 32'(cntb));
        if (rst_n) begin
            if (mv && !madv && cntb < B_MAX) cntb++;
            if (madv) void'(qb.pop_front());
            if (b_flush) qb.delete();
            else if (b_in_valid && rdy) qb.push_back(b_in_data);
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon_a();
        mon_b();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [W-1:0] d);
        a_in_valid = 1'b1;
        a_in_data  = d;
        step();
        a_in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {a_in_valid, a_stall, a_flush, a_out_ready} = '0;
        {b_in_valid, b_stall, b_flush, b_out_ready} = '0;
        a_in_data = '0;
        b_in_data = '0;
        cnta = 0;
        cntb = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // streaming
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'(i);
            step();
        end
        a_in_valid = 1'b0;
        repeat (3) step();

        // backpressure fills the skid entry, then drains in order
        a_stall = 1'b1;
        send_a(32'hA);
        send_a(32'hB);
        repeat (2) step();
        a_stall = 1'b0;
        repeat (3) step();

        // flush with both entries full and a pending input
        a_stall = 1'b1;
        send_a(32'h1A);
        send_a(32'h1B);
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hC;
        step();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("flush_valid", 32'(a_out_valid), 32'd0);
        chk("flush_bubble", a_out_data, c_bub);
        // flush with one entry held while in_ready is high
        send_a(32'h2A);
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hC;
        step();
        a_flush = 1'b0; a_in_valid = 1'b0;
        a_stall = 1'b0;
        repeat (3) step();

        // stall counter saturation
        a_stall = 1'b1;
        send_a(32'h5);
        repeat (20) step();
        chk("cnt_sat", 32'(a_stall_cnt), 32'd15);

        // asynchronous reset with both entries full
        send_a(32'h7);
        chk("pre_rst_occ", 32'(a_occupancy), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(a_out_valid), 32'd0);
        chk("rst_bubble", a_out_data, c_bub);
        chk("rst_occ", 32'(a_occupancy), 32'd0);
        chk("rst_cnt", 32'(a_stall_cnt), 32'd0);
        qa.delete(); qb.delete();
        cnta = 0; cntb = 0;
        a_stall = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // random traffic on both builds
        for (int i = 0; i < 300; i++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_data   = $urandom;
            a_out_ready = 1'($urandom_range(0, 1));
            a_stall     = ($urandom_range(0, 3) == 0);
            a_flush     = ($urandom_range(0, 31) == 0);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_data   = $urandom;
            b_out_ready = 1'($urandom_range(0, 1));
            b_stall     = ($urandom_range(0, 4) == 0);
            step();
        end
        {a_in_valid, a_stall, a_flush} = '0;
        {b_in_valid, b_stall} = '0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
